// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared constants, state encodings and helpers for the truth-table sweeper
//
// Purpose: holds the FSM state encodings, the settle counter width and the
// vector-count derivation used by the sweeper top and its settle counter.
// Ports: none (package).

package truth_table_sweeper_pkg;

  // Settle counter width; covers SETTLE_CYCLES up to 15.
  localparam int CNT_W = 4;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of input combinations for a block with n inputs.
  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// rtl/truth_table_sweeper_settle_counter.sv - per-vector settle counter with terminal-count flag
//
// Purpose: counts the cycles a vector has been held in SETTLE and flags the
// last one so the FSM can move to SAMPLE.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   clr_i  - clear the count to zero (has priority over inc_i)
//   inc_i  - increment the count
//   tc_o   - count equals SETTLE_CYCLES-1

module sweep_settle_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper and truth-table checker for a small logic block
//
// Purpose: on start, drives every input vector of the attached combinational
// block in ascending order, holds each for SETTLE_CYCLES cycles, samples the
// block output into table_out and compares it with the expected table.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   start        - sweep request, accepted only in IDLE without abort
//   abort        - cancel a sweep in progress; blocks a same-cycle start
//   expected     - expected truth table, latched at start accept
//   f_in         - output of the driven logic block
//   vec_out      - currently applied input vector
//   busy         - sweep in progress
//   done         - one-cycle completion pulse
//   table_out    - captured truth table
//   result_valid - table_out/pass/first_fail reflect a completed sweep
//   pass         - captured table matched the expected table
//   first_fail   - lowest mismatching vector index (0 on pass)

module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int NUM_IN        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [num_vec(NUM_IN)-1:0]        expected,
  input  logic                              f_in,
  output logic [NUM_IN-1:0]                 vec_out,
  output logic                              busy,
  output logic                              done,
  output logic [num_vec(NUM_IN)-1:0]        table_out,
  output logic                              result_valid,
  output logic                              pass,
  output logic [NUM_IN-1:0]                 first_fail
);

  localparam int                NUM_VEC  = num_vec(NUM_IN);
  localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(NUM_VEC - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_IN-1:0]  idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NUM_VEC-1:0] table_q, table_d;
  logic [NUM_VEC-1:0] exp_q, exp_d;
  logic               rv_q, rv_d;
  logic               pass_q, pass_d;
  logic [NUM_IN-1:0]  ff_q, ff_d;
  logic               fail_q, fail_d;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               cnt_tc;

  sweep_settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    exp_d   = exp_q;
    rv_d    = rv_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    fail_d  = fail_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          exp_d   = expected;
          table_d = '0;
          rv_d    = 1'b0;
          fail_d  = 1'b0;
          ff_d    = '0;
          idx_d   = '0;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Abort wins over the sample: the partial table keeps only
          // vectors that completed before this cycle.
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end else begin
          table_d[idx_q] = f_in;
          if ((f_in != exp_q[idx_q]) && !fail_q) begin
            ff_d   = idx_q;
            fail_d = 1'b1;
          end
          // Terminal check before increment keeps idx from wrapping.
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        rv_d    = 1'b1;
        pass_d  = ~fail_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      exp_q   <= '0;
      rv_q    <= 1'b0;
      pass_q  <= 1'b0;
      ff_q    <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      rv_q    <= rv_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
      fail_q  <= fail_d;
    end
  end

  // The applied vector is the sample index itself.
  assign vec_out      = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign result_valid = rv_q;
  assign pass         = pass_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper

module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic        pass;
    logic [3:0]  ff;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, abort;
  logic [15:0] exp_a, exp_b;
  logic        f_a, f_b;
  logic [3:0]  vec_a, vec_b, ff_a, ff_b;
  logic        busy_a, busy_b, done_a, done_b, rv_a, rv_b, pass_a, pass_b;
  logic [15:0] tbl_a, tbl_b;

  bit          cur;
  logic [3:0]  c_vec, c_ff;
  logic        c_busy, c_done, c_rv, c_pass;
  logic [15:0] c_tbl;

  int   passed = 0;
  int   total  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & ~v[0]);
  endfunction

  function automatic logic [15:0] model_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = model(4'(i));
    return t;
  endfunction

  assign f_a = model(vec_a);
  assign f_b = model(vec_b);

  assign c_vec  = cur ? vec_b  : vec_a;
  assign c_ff   = cur ? ff_b   : ff_a;
  assign c_busy = cur ? busy_b : busy_a;
  assign c_done = cur ? done_b : done_a;
  assign c_rv   = cur ? rv_b   : rv_a;
  assign c_pass = cur ? pass_b : pass_a;
  assign c_tbl  = cur ? tbl_b  : tbl_a;

  truth_table_sweeper #(.NUM_IN(4), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .expected(exp_a),
    .f_in(f_a), .vec_out(vec_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
    .result_valid(rv_a), .pass(pass_a), .first_fail(ff_a)
  );

  truth_table_sweeper #(.NUM_IN(4), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .expected(exp_b),
    .f_in(f_b), .vec_out(vec_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
    .result_valid(rv_b), .pass(pass_b), .first_fail(ff_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
    end
  endtask

  // One complete sweep: expected results go to the scoreboard at start and
  // are popped and compared when done is seen.
  task automatic run_sweep(input bit sel, input logic [15:0] exp_tbl, input int per,
                           input int restart_at, input string tag);
    exp_t        e;
    exp_t        got_e;
    logic [15:0] t;
    int          lat;
    int          done_at;
    bit          vec_ok;
    t      = model_table();
    e.tbl  = t;
    e.pass = (t == exp_tbl);
    e.ff   = 4'd0;
    for (int i = 15; i >= 0; i--) if (t[i] != exp_tbl[i]) e.ff = 4'(i);
    sbq.push_back(e);
    lat = 1 + 16 * per;
    cur = sel;
    if (sel) begin exp_b = exp_tbl; start_b = 1'b1; end
    else     begin exp_a = exp_tbl; start_a = 1'b1; end
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    // Changing expected after accept must not affect this sweep.
    if (sel) exp_b = ~exp_tbl; else exp_a = ~exp_tbl;
    check({tag, "_busy"}, 32'(c_busy), 32'd1);
    vec_ok  = (c_vec == 4'd0);
    done_at = -1;
    for (int j = 1; j <= lat + 20 && done_at < 0; j++) begin
      if (sel) start_b = (j == restart_at); else start_a = (j == restart_at);
      step();
      if (c_done) begin
        done_at = j;
      end else if (j < 16 * per) begin
        if (c_vec != 4'(j / per)) vec_ok = 1'b0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_vec_seq"}, 32'(vec_ok), 32'd1);
    check({tag, "_latency"}, 32'(done_at), 32'(lat));
    if (done_at >= 0 && sbq.size() > 0) begin
      got_e = sbq.pop_front();
      check({tag, "_table"}, 32'(c_tbl), 32'(got_e.tbl));
      check({tag, "_pass"}, 32'(c_pass), 32'(got_e.pass));
      check({tag, "_first_fail"}, 32'(c_ff), 32'(got_e.ff));
      check({tag, "_rv"}, 32'(c_rv), 32'd1);
      step();
      check({tag, "_done_width"}, 32'({c_done, c_busy, c_rv}), 32'b001);
    end
  endtask

  initial begin
    logic got;
    logic seen;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    exp_a = '0; exp_b = '0; cur = 1'b0;

    repeat (3) step();
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_table", 32'(tbl_a), 32'd0);
    check("rst_rv", 32'(rv_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_ff", 32'(ff_a), 32'd0);
    check("rst_b", 32'({vec_b, busy_b, done_b, tbl_b, rv_b, pass_b, ff_b}), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_hold", 32'({vec_a, busy_a}), 32'd0);
    end

    run_sweep(1'b0, 16'hF444, 3, 0, "pass");
    run_sweep(1'b0, 16'hF440, 3, 0, "fail");
    run_sweep(1'b0, 16'hF444, 3, 20, "restart");

    // Abort while vector 7 is applied.
    exp_a = 16'hF444;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 100 && !got; j++) begin
      if (vec_a == 4'd7) got = 1'b1; else step();
    end
    check("abort_reach7", 32'(got), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_vec", 32'(vec_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_rv", 32'(rv_a), 32'd0);
    check("abort_partial", 32'(tbl_a), 32'(model_table() & 16'h007F));
    seen = 1'b0;
    for (int j = 0; j < 60; j++) begin
      step();
      if (done_a || busy_a) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Start and abort together in IDLE: abort wins.
    start_a = 1'b1;
    abort   = 1'b1;
    step();
    start_a = 1'b0;
    abort   = 1'b0;
    check("collide_busy", 32'(busy_a), 32'd0);
    step();
    check("collide_idle", 32'({busy_a, vec_a, rv_a}), 32'd0);

    run_sweep(1'b1, 16'hF444, 2, 0, "settle1");

    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
